// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Optional feature macro: MIPS_MC_JUMP_EN (adds the JUMP state for opcode 000010).
package mips_mc_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CODE_W = 3;
    localparam int unsigned ALUOP_W    = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes (zero-extended onto the ALUControl port)
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

    // ALUOp requests from the sequencer to the ALU decoder
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B source and PC source selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXE,
        S_ADDIWB
`ifdef MIPS_MC_JUMP_EN
        ,
        S_JUMP
`endif
    } mc_state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the sequencer's ALUOp request (add / sub / funct) to an ALUControl code.
module mips_alu_decoder
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic [ALUOP_W-1:0]    i_alu_op,
    input  logic [FUNCT_W-1:0]    i_funct,
    output logic [ALU_CTRL_W-1:0] o_alu_control_c
);

    logic [ALU_CODE_W-1:0] w_code;

    // Select the ALU code; unknown funct values fall back to ADD.
    always_comb begin
        w_code = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: w_code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  w_code = ALU_ADD;
                    FN_SUB:  w_code = ALU_SUB;
                    FN_AND:  w_code = ALU_AND;
                    FN_OR:   w_code = ALU_OR;
                    FN_SLT:  w_code = ALU_SLT;
                    default: w_code = ALU_ADD;
                endcase
            end
            default: w_code = ALU_ADD;
        endcase
    end

    assign o_alu_control_c = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: sequences each instruction through FETCH,
// DECODE and per-class execute/write-back states, stalling on mem_ready.
// Outputs are decoded combinationally from the registered state (suffix _c).
// Optional feature macro: MIPS_MC_JUMP_EN (executes j via a JUMP state).
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OP_W-1:0]       i_op,
    input  logic [FUNCT_W-1:0]    i_funct,
    input  logic                  i_zero,
    input  logic                  i_mem_ready,
    output logic                  o_iord_c,
    output logic                  o_mem_write_c,
    output logic                  o_ir_write_c,
    output logic                  o_pc_en_c,
    output logic                  o_reg_dst_c,
    output logic                  o_mem_to_reg_c,
    output logic                  o_reg_write_c,
    output logic                  o_alu_src_a_c,
    output logic [1:0]            o_alu_src_b_c,
    output logic [1:0]            o_pc_src_c,
    output logic [ALU_CTRL_W-1:0] o_alu_control_c,
    output logic                  o_instr_done_c,
    output logic                  o_illegal_op_c
);

    mc_state_t            r_state;
    mc_state_t            w_next;
    logic                 w_iord;
    logic                 w_mem_write;
    logic                 w_ir_write;
    logic                 w_pc_en;
    logic                 w_reg_dst;
    logic                 w_mem_to_reg;
    logic                 w_reg_write;
    logic                 w_alu_src_a;
    logic [1:0]           w_alu_src_b;
    logic [1:0]           w_pc_src;
    logic [ALUOP_W-1:0]   w_alu_op;
    logic                 w_instr_done;
    logic                 w_illegal_op;

    // State register; reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next       = r_state;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_en      = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_pc_src     = PCSRC_ALU;
        w_alu_op     = ALUOP_ADD;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_alu_src_b = SRCB_FOUR;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = SRCB_IMM_SH;
                case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXE;
`ifdef MIPS_MC_JUMP_EN
                    OP_J:         w_next = S_JUMP;
`endif
                    default: begin
                        w_next       = S_FETCH;
                        w_illegal_op = 1'b1;
                        w_instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_next      = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (i_mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                // Write held until accepted; leaving on acceptance prevents a second commit.
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (i_mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_REG;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_REG;
                w_alu_op     = ALUOP_SUB;
                w_pc_src     = PCSRC_ALUOUT;
                w_pc_en      = i_zero;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_ADDIEXE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef MIPS_MC_JUMP_EN
            S_JUMP: begin
                w_pc_src     = PCSRC_JUMP;
                w_pc_en      = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    mips_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (i_funct),
        .o_alu_control_c (o_alu_control_c)
    );

    // Write enables and pulses are suppressed while reset is held.
    assign o_iord_c       = w_iord;
    assign o_mem_write_c  = w_mem_write & rst_n;
    assign o_ir_write_c   = w_ir_write & rst_n;
    assign o_pc_en_c      = w_pc_en & rst_n;
    assign o_reg_dst_c    = w_reg_dst;
    assign o_mem_to_reg_c = w_mem_to_reg;
    assign o_reg_write_c  = w_reg_write & rst_n;
    assign o_alu_src_a_c  = w_alu_src_a;
    assign o_alu_src_b_c  = w_alu_src_b;
    assign o_pc_src_c     = w_pc_src;
    assign o_instr_done_c = w_instr_done & rst_n;
    assign o_illegal_op_c = w_illegal_op & rst_n;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: an instruction-level model expands
// each instruction into its expected per-cycle control vectors.
// Honours MIPS_MC_JUMP_EN the same way as the design.
module tb_mips_mc_control;
    import mips_mc_pkg::*;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned VEC_W = 14 + ALU_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, pc_src;
    logic [ALU_W-1:0] alu_control;
    logic             instr_done, illegal_op;
    logic [VEC_W-1:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [VEC_W-1:0] exp;
        logic             rdy;
        logic             z;
        string            phase;
    } cyc_t;

    cyc_t q[$];

    mips_mc_control #(.ALU_CTRL_W(ALU_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_op            (op),
        .i_funct         (funct),
        .i_zero          (zero),
        .i_mem_ready     (mem_ready),
        .o_iord_c        (iord),
        .o_mem_write_c   (mem_write),
        .o_ir_write_c    (ir_write),
        .o_pc_en_c       (pc_en),
        .o_reg_dst_c     (reg_dst),
        .o_mem_to_reg_c  (mem_to_reg),
        .o_reg_write_c   (reg_write),
        .o_alu_src_a_c   (alu_src_a),
        .o_alu_src_b_c   (alu_src_b),
        .o_pc_src_c      (pc_src),
        .o_alu_control_c (alu_control),
        .o_instr_done_c  (instr_done),
        .o_illegal_op_c  (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, pc_src, alu_control, instr_done, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] mk(input logic io, mw, irw, pce, rd, m2r, rw, sa,
                                            input logic [1:0] sb, ps,
                                            input logic [2:0] alu,
                                            input logic dn, il);
        return {io, mw, irw, pce, rd, m2r, rw, sa, sb, ps, ALU_W'(alu), dn, il};
    endfunction

    // Expected ALU code for an R-type funct.
    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [VEC_W-1:0] e, input logic r, input logic z, input string ph);
        cyc_t c;
        c.exp = e; c.rdy = r; c.z = z; c.phase = ph;
        q.push_back(c);
    endtask

    // Builds the expected cycle list for one instruction. wf/wm are the number
    // of not-ready cycles in fetch and in the data memory access; zf<0 = random zero.
    task automatic plan(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm, input int zf);
        logic z;
        bit   legal;
        q.delete();
        for (int i = 0; i < wf; i++) push(mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0), 1'b0, rbit(), "fetch_wait");
        push(mk(0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010,0,0), 1'b1, rbit(), "fetch");
        legal = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) || (o == 6'b000100) || (o == 6'b001000);
`ifdef MIPS_MC_JUMP_EN
        if (o == 6'b000010) legal = 1'b1;
`endif
        if (!legal) begin
            push(mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1,1), rbit(), rbit(), "decode_illegal");
            return;
        end
        push(mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0), rbit(), rbit(), "decode");
        case (o)
            6'b100011: begin
                push(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), rbit(), rbit(), "memadr");
                for (int i = 0; i < wm; i++) push(mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b0, rbit(), "memrd_wait");
                push(mk(1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b1, rbit(), "memrd");
                push(mk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,1,0), rbit(), rbit(), "memwb");
            end
            6'b101011: begin
                push(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), rbit(), rbit(), "memadr");
                for (int i = 0; i < wm; i++) push(mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0), 1'b0, rbit(), "memwr_wait");
                push(mk(1,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,1,0), 1'b1, rbit(), "memwr");
            end
            6'b000000: begin
                push(mk(0,0,0,0,0,0,0,1,2'b00,2'b00,r_alu(f),0,0), rbit(), rbit(), "execute");
                push(mk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,1,0), rbit(), rbit(), "aluwb");
            end
            6'b000100: begin
                z = (zf < 0) ? rbit() : 1'(zf);
                push(mk(0,0,0,z,0,0,0,1,2'b00,2'b01,3'b110,1,0), rbit(), z, "branch");
            end
            6'b001000: begin
                push(mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0), rbit(), rbit(), "addiexe");
                push(mk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,1,0), rbit(), rbit(), "addiwb");
            end
            default: begin
                push(mk(0,0,0,1,0,0,0,0,2'b00,2'b10,3'b010,1,0), rbit(), rbit(), "jump");
            end
        endcase
    endtask

    // Drives the planned cycles (all of them, or only the first n when n >= 0).
    task automatic run(input string name, input logic [5:0] o, input logic [5:0] f, input int n);
        int lim;
        op = o;
        funct = f;
        lim = (n < 0 || n > q.size()) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready = q[i].rdy;
            zero      = q[i].z;
            @(negedge clk);
            chk($sformatf("%s/%s", name, q[i].phase), 32'(obs), 32'(q[i].exp));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input int wf, input int wm, input int zf);
        plan(o, f, wf, wm, zf);
        run(name, o, f, -1);
    endtask

    logic [VEC_W-1:0] rst_vec;
    logic [5:0]       ops[6];
    logic [5:0]       fns[6];

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        rst_vec = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);

        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_hold", 32'(obs), 32'(rst_vec));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        do_instr("lw_fast", 6'b100011, 6'b000000, 0, 0, -1);
        do_instr("sw_wait3", 6'b101011, 6'b000000, 0, 3, -1);
        do_instr("slt", 6'b000000, 6'b101010, 0, 0, -1);
        do_instr("beq_z1", 6'b000100, 6'b000000, 0, 0, 1);
        do_instr("beq_z0", 6'b000100, 6'b000000, 0, 0, 0);
        do_instr("j", 6'b000010, 6'b000000, 0, 0, -1);
        do_instr("addi_fwait", 6'b001000, 6'b000000, 2, 0, -1);
        do_instr("illegal", 6'b111111, 6'b000000, 0, 0, -1);

        // Reset while lw waits in MEMRD: no writes during reset, then FETCH.
        plan(6'b100011, 6'b000000, 0, 3, -1);
        run("lw_abort", 6'b100011, 6'b000000, 4);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_reset", 32'(obs), 32'(rst_vec));
        chk("abort_no_regwrite", 32'(reg_write), 32'd0);
        chk("abort_no_memwrite", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_instr("after_abort", 6'b000000, 6'b100010, 0, 0, -1);

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            do_instr($sformatf("rnd%0d_op%0h", k, o), o, f,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
